// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port at the end of Writeback between
//   the in-order pipeline result and out-of-band long-latency (MUL/DIV) results.
//   The pipeline normally owns the port. Long-latency results wait in a small
//   FIFO and use idle port cycles. A result denied for STARVE_MAX cycles raises
//   stall_req for one cycle so that it can take the port.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   pipe_we/rd/wd     pipeline writeback (RegWriteW, RdW, ResultW)
//   lu_valid/rd/wd    long-latency result offered for enqueue
//   lu_ready          FIFO not full (derived from registered pointers)
//   rf_we/rd/wd       register-file write port (combinational)
//   stall_req         registered request to freeze IF..W
//   pending           per-slot valid bits, used by the hazard unit
module wb_port_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_we,
  input  logic [4:0]       pipe_rd,
  input  logic [31:0]      pipe_wd,
  input  logic             lu_valid,
  output logic             lu_ready,
  input  logic [4:0]       lu_rd,
  input  logic [31:0]      lu_wd,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [31:0]      rf_wd,
  output logic             stall_req,
  output logic [DEPTH-1:0] pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_MAX) + 1;

  typedef enum logic [1:0] {IDLE, PEND, STALL} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     wait_cnt, wait_nxt;

  logic [AW:0]       wptr, rptr, wptr_nxt, rptr_nxt;
  logic [4:0]        rd_q [DEPTH];
  logic [31:0]       wd_q [DEPTH];
  logic [DEPTH-1:0]  vld, vld_nxt;

  logic [AW-1:0]     head_idx, tail_idx;
  logic              empty, full, head_vld;
  logic              grant_pipe, grant_lu;
  logic              push, pop;
  logic              head_killed, denied, nxt_head_vld;

  assign head_idx = rptr[AW-1:0];
  assign tail_idx = wptr[AW-1:0];
  // Extra MSB on the pointers distinguishes full from empty when the low bits match.
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head_vld = !empty && vld[head_idx];

  assign lu_ready  = !full;
  assign stall_req = (state == STALL);
  assign pending   = vld;

  // Port grant: a starved head during a stall, then the pipeline, then the FIFO.
  always_comb begin
    grant_pipe = 1'b0;
    grant_lu   = 1'b0;
    rf_we      = 1'b0;
    rf_rd      = 5'd0;
    rf_wd      = 32'd0;
    if (!rst) begin
      if (stall_req && head_vld) begin
        grant_lu = 1'b1;
      end else if (pipe_we && (pipe_rd != 5'd0)) begin
        grant_pipe = 1'b1;
      end else if (head_vld) begin
        grant_lu = 1'b1;
      end
    end
    if (grant_pipe) begin
      rf_we = 1'b1;
      rf_rd = pipe_rd;
      rf_wd = pipe_wd;
    end else if (grant_lu) begin
      rf_we = 1'b1;
      rf_rd = rd_q[head_idx];
      rf_wd = wd_q[head_idx];
    end
  end

  // A killed entry at the head is discarded without using the port. A head
  // kill only happens under grant_pipe, so it can never coincide with grant_lu.
  assign pop  = !rst && !empty && (grant_lu || !vld[head_idx]);
  // Full is checked before this cycle's pop, so a full FIFO never accepts.
  assign push = !rst && lu_valid && !full && (lu_rd != 5'd0);

  assign rptr_nxt = rptr + (AW+1)'(pop);
  assign wptr_nxt = wptr + (AW+1)'(push);

  // Valid bits: WAW kill first, then pop, then push, so a same-cycle push to
  // the killed register survives as the younger write.
  always_comb begin
    vld_nxt = vld;
    if (grant_pipe) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_q[i] == pipe_rd) vld_nxt[i] = 1'b0;
      end
    end
    if (pop)  vld_nxt[head_idx] = 1'b0;
    if (push) vld_nxt[tail_idx] = 1'b1;
  end

  assign nxt_head_vld = (rptr_nxt != wptr_nxt) && vld_nxt[rptr_nxt[AW-1:0]];
  assign head_killed  = head_vld && grant_pipe && (rd_q[head_idx] == pipe_rd);
  assign denied       = head_vld && !grant_lu && !head_killed;

  // Starvation FSM: the default path covers pops, kills, stall exit and the
  // empty FIFO; only a denied head carries its wait count forward.
  always_comb begin
    state_nxt = nxt_head_vld ? PEND : IDLE;
    wait_nxt  = '0;
    unique case (state)
      IDLE, PEND: begin
        if (denied) begin
          if (wait_cnt == CW'(STARVE_MAX - 1)) begin
            state_nxt = STALL;
          end else begin
            wait_nxt = wait_cnt + CW'(1);
          end
        end
      end
      STALL: begin
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      wptr     <= '0;
      rptr     <= '0;
      vld      <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      wptr     <= wptr_nxt;
      rptr     <= rptr_nxt;
      vld      <= vld_nxt;
    end
  end

  // FIFO payload storage; the valid bits alone decide what is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail_idx] <= lu_rd;
      wd_q[tail_idx] <= lu_wd;
    end
  end

endmodule
